master_out_port: RTL
====================

# master_out_port

Master-side serializer that sits directly upstream of the slave input port on the serial bus. It accepts a parallel read/write request from the master core, performs the m_valid/s_ready handshake, and shifts the 12-bit address and 8-bit data LSB-first onto the bit-serial address and data lines. For write bursts it also streams each additional data beat. Read-burst continuation is owned by the slave.

## Interface
- ADDR_W, 12, address width / address frame length in cycles
- DATA_W, 8, data width / data frame length in cycles
- BURST_W, 13, burst field width; bit 0 = burst mode, bits [BURST_W-1:1] = number of additional beats
- clk  in  1  single clock; all logic on rising edge
- rstn  in  1  reset, asynchronous, active-low
- req_valid  in  1  master core request valid
- req_ready  out  1  block idle and able to accept a request
- req_addr  in  ADDR_W  start address
- req_wdata  in  DATA_W  first write data beat
- req_write  in  1  1 = write, 0 = read
- req_burst  in  BURST_W  burst control, passed through to the bus
- beat_valid  in  1  next write-burst data beat valid
- beat_ready  out  1  block ready for next write-burst beat
- beat_wdata  in  DATA_W  write-burst beat data
- m_valid  out  1  bus handshake valid
- s_ready  in  1  slave ready
- tx_address  out  1  serial address line
- tx_data  out  1  serial data line
- read_enable, write_enable  out  1 each  transfer type, held for the whole transaction
- burst  out  BURST_W  registered copy of req_burst
- busy  out  1  high in any state other than IDLE

## Operation
- Transfer states: IDLE, ADDR_HS, ADDR_SHIFT, BEAT_WAIT, BEAT_HS, BEAT_SHIFT.
- Output rules:
  - All outputs are registered.
  - Reset values: req_ready=1; all other outputs 0; burst=0.
  - Internal shift registers and counters reset to 0.
- IDLE:
  - req_ready=1.
  - On req_valid, capture addr, wdata, write and burst. Drive write_enable=req_write and read_enable=!req_write. Go to ADDR_HS.
- ADDR_HS:
  - m_valid=1, tx_address=addr[0], tx_data=(write ? wdata[0] : 0).
  - Hold until s_ready=1. The cycle with m_valid && s_ready is the handshake cycle H.
- ADDR_SHIFT:
  - m_valid=0.
  - In cycle H+k, k = 1..11, drive tx_address=addr[k].
  - For writes, drive tx_data=wdata[k] for k = 1..7; otherwise tx_data=0.
  - s_ready is ignored in this state.
- End of address frame:
  - If write, burst[0]=1 and burst[12:1] != 0: go to BEAT_WAIT and clear the beat counter.
  - Otherwise go to IDLE and clear read_enable, write_enable and burst.
- BEAT_WAIT:
  - beat_ready=1. tx_address=0, tx_data=0.
  - On beat_valid, capture beat_wdata and go to BEAT_HS.
- BEAT_HS:
  - m_valid=1, tx_data=beat[0]. Hold until s_ready=1 (handshake cycle B).
- BEAT_SHIFT:
  - Drive tx_data=beat[k] in cycle B+k, k = 1..7, then increment the 12-bit beat counter.
  - If counter == burst[12:1], go to IDLE; otherwise go to BEAT_WAIT.
- Boundary cases:
  - req_valid outside IDLE is ignored.
  - beat_valid outside BEAT_WAIT is ignored.
  - A read with burst[0]=1 sends one address frame only.
  - burst[0]=1 with burst[12:1]=0 behaves as a single transfer.
  - Reset mid-transaction aborts immediately: all outputs return to their reset values and nothing resumes after reset.

## Timing
- Request acceptance:
  - Request accepted at edge T; m_valid rises in cycle T+1.
  - Minimum handshake is H = T+1.
- Address frame:
  - The address frame occupies cycles H..H+11.
  - req_ready=1 again in cycle H+12 for non-burst transfers.
  - Back-to-back minimum period is 13 cycles.
- Data timing:
  - Write data occupies cycles H..H+7.
  - tx_data is 0 in cycles H+8..H+11.
- Burst beats:
  - The first BEAT_WAIT cycle is H+12.
  - Each beat takes at least 1 (wait) + 1 (handshake) + 7 cycles.
- m_valid is high only in ADDR_HS and BEAT_HS, and is never high for two handshakes without an intervening shift.
- read_enable and write_enable are stable from T+1 until the cycle before returning to IDLE.

## Test plan
- Single write:
  - Stimulus: addr=0xA5C, data=0x3B, s_ready=1.
  - Response: m_valid high only at H=T+1; tx_address over H..H+11 = 0,0,1,1,1,0,1,0,0,1,0,1; tx_data over H..H+7 = 1,1,0,1,1,1,0,0; req_ready=1 at H+12.
- Single read:
  - Stimulus: addr=0x001, with s_ready held 0 for 5 cycles.
  - Response: m_valid held 5 cycles; tx_address=1 at H then 0; tx_data=0 throughout; read_enable=1 until H+11.
- Write burst:
  - Stimulus: burst=13'b0000000000101 (2 extra beats), beats 0x81 and 0x7E.
  - Response: two beat handshakes, each followed by 7 shifted bits LSB-first; IDLE after the second beat; 3 data beats total.
- Stray inputs:
  - Stimulus: req_valid pulses during ADDR_SHIFT, and beat_valid in IDLE.
  - Response: neither is captured; no extra m_valid.
- Reset mid-frame:
  - Stimulus: rstn=0 at H+5.
  - Response: all outputs take reset values in the same cycle; req_ready=1 once rstn rises; no frame resumes.

Source files
------------

// File: rtl/master_out_port.sv
// Master-side bit-serial bus port: request handshake, LSB-first address and data
// shifting, write-burst beat streaming. Ports: req_*, beat_*, m_valid/s_ready, tx_*, enables.
module master_out_port #(
  parameter int ADDR_W  = 12,
  parameter int DATA_W  = 8,
  parameter int BURST_W = 13
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [ADDR_W-1:0]  req_addr,
  input  logic [DATA_W-1:0]  req_wdata,
  input  logic               req_write,
  input  logic [BURST_W-1:0] req_burst,
  input  logic               beat_valid,
  output logic               beat_ready,
  input  logic [DATA_W-1:0]  beat_wdata,
  output logic               m_valid,
  input  logic               s_ready,
  output logic               tx_address,
  output logic               tx_data,
  output logic               read_enable,
  output logic               write_enable,
  output logic [BURST_W-1:0] burst,
  output logic               busy
);

  localparam int CW = $clog2(ADDR_W);
  localparam int NW = BURST_W - 1;

  typedef enum logic [2:0] {
    IDLE, ADDR_HS, ADDR_SHIFT,
    BEAT_WAIT, BEAT_HS, BEAT_SHIFT
  } state_t;

  state_t state, state_n;

  logic [ADDR_W-1:0]  addr_sr, addr_n;
  logic [DATA_W-1:0]  data_sr, data_n;
  logic [CW-1:0]      cnt, cnt_n;
  logic [NW-1:0]      bcnt, bcnt_n;
  logic               write_q, write_n;
  logic               req_ready_n, beat_ready_n;
  logic               m_valid_n, tx_addr_n, tx_data_n;
  logic               re_n, we_n;
  logic [BURST_W-1:0] burst_n;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state        <= IDLE;
      addr_sr      <= '0;
      data_sr      <= '0;
      cnt          <= '0;
      bcnt         <= '0;
      write_q      <= 1'b0;
      req_ready    <= 1'b1;
      beat_ready   <= 1'b0;
      m_valid      <= 1'b0;
      tx_address   <= 1'b0;
      tx_data      <= 1'b0;
      read_enable  <= 1'b0;
      write_enable <= 1'b0;
      burst        <= '0;
      busy         <= 1'b0;
    end else begin
      state        <= state_n;
      addr_sr      <= addr_n;
      data_sr      <= data_n;
      cnt          <= cnt_n;
      bcnt         <= bcnt_n;
      write_q      <= write_n;
      req_ready    <= req_ready_n;
      beat_ready   <= beat_ready_n;
      m_valid      <= m_valid_n;
      tx_address   <= tx_addr_n;
      tx_data      <= tx_data_n;
      read_enable  <= re_n;
      write_enable <= we_n;
      burst        <= burst_n;
      busy         <= (state_n != IDLE);
    end
  end

  // Outputs are computed one cycle ahead so every port is a flop.
  // Shifting zeros into data_sr yields tx_data=0 past the data frame.
  always_comb begin
    state_n      = state;
    addr_n       = addr_sr;
    data_n       = data_sr;
    cnt_n        = cnt;
    bcnt_n       = bcnt;
    write_n      = write_q;
    req_ready_n  = req_ready;
    beat_ready_n = beat_ready;
    m_valid_n    = m_valid;
    tx_addr_n    = tx_address;
    tx_data_n    = tx_data;
    re_n         = read_enable;
    we_n         = write_enable;
    burst_n      = burst;
    unique case (state)
      IDLE: begin
        if (req_valid) begin
          state_n     = ADDR_HS;
          addr_n      = req_addr;
          data_n      = req_write ? req_wdata : '0;
          write_n     = req_write;
          burst_n     = req_burst;
          we_n        = req_write;
          re_n        = !req_write;
          req_ready_n = 1'b0;
          m_valid_n   = 1'b1;
          tx_addr_n   = req_addr[0];
          tx_data_n   = req_write & req_wdata[0];
          cnt_n       = '0;
        end
      end
      ADDR_HS: begin
        if (s_ready) begin
          state_n   = ADDR_SHIFT;
          m_valid_n = 1'b0;
          addr_n    = addr_sr >> 1;
          data_n    = data_sr >> 1;
          tx_addr_n = addr_sr[1];
          tx_data_n = data_sr[1];
          cnt_n     = CW'(1);
        end
      end
      ADDR_SHIFT: begin
        if (cnt == CW'(ADDR_W - 1)) begin
          tx_addr_n = 1'b0;
          tx_data_n = 1'b0;
          if (write_q && burst[0] &&
              (burst[BURST_W-1:1] != '0)) begin
            state_n      = BEAT_WAIT;
            bcnt_n       = '0;
            beat_ready_n = 1'b1;
          end else begin
            state_n     = IDLE;
            req_ready_n = 1'b1;
            re_n        = 1'b0;
            we_n        = 1'b0;
            burst_n     = '0;
          end
        end else begin
          addr_n    = addr_sr >> 1;
          data_n    = data_sr >> 1;
          tx_addr_n = addr_sr[1];
          tx_data_n = data_sr[1];
          cnt_n     = cnt + 1'b1;
        end
      end
      BEAT_WAIT: begin
        if (beat_valid) begin
          state_n      = BEAT_HS;
          data_n       = beat_wdata;
          beat_ready_n = 1'b0;
          m_valid_n    = 1'b1;
          tx_data_n    = beat_wdata[0];
        end
      end
      BEAT_HS: begin
        if (s_ready) begin
          state_n   = BEAT_SHIFT;
          m_valid_n = 1'b0;
          data_n    = data_sr >> 1;
          tx_data_n = data_sr[1];
          cnt_n     = CW'(1);
        end
      end
      BEAT_SHIFT: begin
        if (cnt == CW'(DATA_W - 1)) begin
          tx_data_n = 1'b0;
          bcnt_n    = bcnt + 1'b1;
          if (bcnt_n == burst[BURST_W-1:1]) begin
            state_n     = IDLE;
            req_ready_n = 1'b1;
            re_n        = 1'b0;
            we_n        = 1'b0;
            burst_n     = '0;
          end else begin
            state_n      = BEAT_WAIT;
            beat_ready_n = 1'b1;
          end
        end else begin
          data_n    = data_sr >> 1;
          tx_data_n = data_sr[1];
          cnt_n     = cnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule
